// File: rtl/or3_pattern_tester.sv
// or3_pattern_tester
//
// Exhaustive pattern tester for a 3-input OR gate. A start request walks the
// eight input vectors 000..111 (a is the MSB), waits SETTLE_CYCLES cycles for
// the unit under test to settle, then compares its response y with a|b|c.
// Mismatches are counted and the first failing vector is remembered.
//
// Parameters
//   SETTLE_CYCLES : cycles waited after applying a vector before y is sampled
//                   (legal 1..15)
//
// Ports
//   clk         : clock, all state changes on its rising edge
//   rst         : asynchronous active-high reset
//   start       : one-cycle run request, only honoured while idle
//   a, b, c     : stimulus to the unit under test
//   y           : response from the unit under test (synchronous to clk)
//   busy        : high from the first applied vector through the done cycle
//   done        : one-cycle pulse at the end of a run
//   pass        : last completed run had no mismatches
//   err_count   : mismatching vectors in the current or last run (saturates)
//   fail_vector : {a,b,c} of the first mismatch, 000 when there is none
//
// Build option
//   OR3_TESTER_STOP_ON_FAIL_EN : when defined, the first mismatch ends the run
//                                immediately.

`timescale 1ns/1ps

module or3_pattern_tester #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] fail_vector
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    APPLY  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    FINISH = 3'd4
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  // Golden response of a 3-input OR for a given {a,b,c} vector.
  function automatic logic or3_expect(input logic [2:0] vec);
    return vec[2] | vec[1] | vec[0];
  endfunction

  state_t     state_r, state_s;
  logic [2:0] vector_r, vector_s;
  logic [3:0] cnt_r, cnt_s;
  logic [3:0] err_r, err_s;
  logic [2:0] fail_r, fail_s;
  logic       pass_r, pass_s;
  logic [2:0] stim_r, stim_s;
  logic       busy_r, busy_s;
  logic       done_r, done_s;
  logic       mismatch_s;

  // Next-state, datapath updates and next values of the registered outputs.
  always_comb begin
    state_s    = state_r;
    vector_s   = vector_r;
    cnt_s      = cnt_r;
    err_s      = err_r;
    fail_s     = fail_r;
    pass_s     = pass_r;
    mismatch_s = 1'b0;

    case (state_r)
      IDLE: begin
        if (start) begin
          vector_s = 3'd0;
          err_s    = 4'd0;
          fail_s   = 3'd0;
          pass_s   = 1'b0;
          state_s  = APPLY;
        end else begin
          state_s  = IDLE;
        end
      end

      APPLY: begin
        cnt_s   = SETTLE_LOAD;
        state_s = SETTLE;
      end

      SETTLE: begin
        cnt_s = cnt_r - 4'd1;
        // A count of 1 (or a corrupted 0) is the last settle cycle.
        if (cnt_r <= 4'd1) begin
          state_s = CHECK;
        end else begin
          state_s = SETTLE;
        end
      end

      CHECK: begin
        mismatch_s = (y != or3_expect(vector_r));
        if (mismatch_s) begin
          if (err_r != 4'd15) begin
            err_s = err_r + 4'd1;
          end else begin
            err_s = err_r;
          end
          // Only the first failing vector of a run is kept.
          if (err_r == 4'd0) begin
            fail_s = vector_r;
          end else begin
            fail_s = fail_r;
          end
        end else begin
          err_s  = err_r;
          fail_s = fail_r;
        end
`ifdef OR3_TESTER_STOP_ON_FAIL_EN
        if (mismatch_s || (vector_r == 3'd7)) begin
          state_s = FINISH;
        end else begin
          vector_s = vector_r + 3'd1;
          state_s  = APPLY;
        end
`else
        if (vector_r == 3'd7) begin
          state_s = FINISH;
        end else begin
          vector_s = vector_r + 3'd1;
          state_s  = APPLY;
        end
`endif
      end

      FINISH: begin
        state_s = IDLE;
      end

      default: begin
        state_s = IDLE;
      end
    endcase

    // pass is set on FINISH entry so it is valid together with done.
    if (state_s == FINISH) begin
      pass_s = (err_s == 4'd0);
    end else begin
      pass_s = pass_s;
    end

    // Outputs are registered from next-state values so they line up with
    // the state they belong to without extra latency.
    if ((state_s == APPLY) || (state_s == SETTLE) || (state_s == CHECK)) begin
      stim_s = vector_s;
    end else begin
      stim_s = 3'd0;
    end
    busy_s = (state_s != IDLE);
    done_s = (state_s == FINISH);
  end

  // State, datapath and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      vector_r <= 3'd0;
      cnt_r    <= 4'd0;
      err_r    <= 4'd0;
      fail_r   <= 3'd0;
      pass_r   <= 1'b0;
      stim_r   <= 3'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      vector_r <= vector_s;
      cnt_r    <= cnt_s;
      err_r    <= err_s;
      fail_r   <= fail_s;
      pass_r   <= pass_s;
      stim_r   <= stim_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
    end
  end

  assign a           = stim_r[2];
  assign b           = stim_r[1];
  assign c           = stim_r[0];
  assign busy        = busy_r;
  assign done        = done_r;
  assign pass        = pass_r;
  assign err_count   = err_r;
  assign fail_vector = fail_r;

endmodule

// File: tb/tb_or3_pattern_tester.sv
// Self-checking bench for or3_pattern_tester. The unit under test is modelled
// as a|b|c with a per-vector fault mask (flip_mask[v] inverts the response for
// vector v). A reference model derives, for every cycle of a run, the expected
// busy/done/pass/stimulus/err_count/fail_vector from the mask alone.

`timescale 1ns/1ps

module tb_or3_pattern_tester;

  localparam int S  = 2;
  localparam int VC = S + 2;

  logic       clk;
  logic       rst;
  logic       start;
  logic       a, b, c, y;
  logic       busy, done, pass;
  logic [3:0] err_count;
  logic [2:0] fail_vector;
  logic [7:0] flip_mask;

  int n_checks;
  int n_fail;

  or3_pattern_tester #(.SETTLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .c           (c),
    .y           (y),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .err_count   (err_count),
    .fail_vector (fail_vector)
  );

  // Faulty OR gate model.
  assign y = (a | b | c) ^ flip_mask[{a, b, c}];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] observed();
    return {busy, done, pass, a, b, c, err_count, fail_vector};
  endfunction

  task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got={busy,done,pass,abc,err,fail}=%b_%b_%b_%b_%b_%b exp=%b_%b_%b_%b_%b_%b",
               tag, got[12], got[11], got[10], got[9:7], got[6:3], got[2:0],
               exp[12], exp[11], exp[10], exp[9:7], exp[6:3], exp[2:0]);
    end
  endtask

  // First failing vector index, or 8 when the mask is clean.
  function automatic int first_fail(input logic [7:0] fl);
    for (int v = 0; v < 8; v++) begin
      if (fl[v]) return v;
    end
    return 8;
  endfunction

  // Cycle index (counted from the cycle after start is sampled) of done.
  function automatic int run_length(input logic [7:0] fl);
`ifdef OR3_TESTER_STOP_ON_FAIL_EN
    if (first_fail(fl) < 8) return (first_fail(fl) + 1) * VC;
`endif
    return 8 * VC;
  endfunction

  // Expected outputs at run cycle n (n > t means back in idle).
  function automatic logic [12:0] expect_at(input int n, input logic [7:0] fl);
    int t, completed, errs, first;
    logic [2:0] abc;
    t         = run_length(fl);
    completed = (n < t) ? (n / VC) : (t / VC);
    errs      = 0;
    first     = -1;
    for (int v = 0; v < completed; v++) begin
      if (fl[v]) begin
        errs++;
        if (first < 0) first = v;
      end
    end
    abc = (n < t) ? 3'(n / VC) : 3'd0;
    return {(n <= t), (n == t), ((n >= t) && (errs == 0)), abc,
            4'(errs), (first < 0) ? 3'd0 : 3'(first)};
  endfunction

  task automatic run_test(input string tag, input logic [7:0] fl, input bit repulse);
    int t;
    flip_mask = fl;
    t = run_length(fl);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n <= t + 3; n++) begin
      if (n > 0) @(negedge clk);
      check($sformatf("%s_cyc%0d", tag, n), observed(), expect_at(n, fl));
      // Extra start pulses at vectors 010 and 101 must be ignored.
      start = (repulse && ((n == 2 * VC + 1) || (n == 5 * VC + 1))) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic reset_midrun();
    flip_mask = 8'h00;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3 * VC + 1) @(negedge clk);
    check("pre_rst_v011", observed(), expect_at(3 * VC + 1, 8'h00));
    #2 rst = 1'b1;
    #1 check("rst_async", observed(), 13'd0);
    @(negedge clk);
    check("rst_held", observed(), 13'd0);
    rst = 1'b0;
    for (int n = 0; n < 10 * VC; n++) begin
      @(negedge clk);
      check($sformatf("post_rst_%0d", n), observed(), 13'd0);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b0;
    start     = 1'b0;
    flip_mask = 8'h00;
    #2 rst = 1'b1;
    #1 check("reset_async", observed(), 13'd0);
    repeat (2) @(negedge clk);
    check("reset_held", observed(), 13'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle", observed(), 13'd0);

    run_test("clean",   8'h00, 1'b0);
    run_test("stuck0",  8'hFE, 1'b0);
    run_test("stuck1",  8'h01, 1'b0);
    run_test("repulse", 8'h00, 1'b1);
    run_test("repulse_f", 8'h24, 1'b1);
    reset_midrun();
    run_test("after_rst", 8'h00, 1'b0);
    for (int i = 0; i < 12; i++) begin
      run_test($sformatf("rand%0d", i), 8'($urandom), 1'($urandom));
    end
    // A start during idle after the last run produces a full clean run again.
    run_test("final_clean", 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/or3_pattern_tester.md
OR3_PATTERN_TESTER -- requirements
Module: or3_pattern_tester

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, meaning cycles to wait after applying a vector before sampling y (legal 1..15).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have port start, input, 1, a one-cycle request to run the full 8-vector test; sampled only in IDLE.
REQ-005 SHALL have ports a, b, c, output, 1 each, stimulus driven to the 3-input OR unit under test.
REQ-006 SHALL have port y, input, 1, the response from the unit under test.
REQ-007 SHALL have port busy, output, 1, high while a test run is in progress.
REQ-008 SHALL have port done, output, 1, a one-cycle pulse at the end of a run.
REQ-009 SHALL have port pass, output, 1, high when the last completed run had zero mismatches.
REQ-010 SHALL have port err_count, output, 4, the number of mismatching vectors in the current or last run.
REQ-011 SHALL have port fail_vector, output, 3, the {a,b,c} value of the first mismatch in the current or last run.

Function
REQ-012 SHALL implement a state machine with states IDLE, APPLY, SETTLE, CHECK and FINISH.
REQ-013 IDLE: a=b=c=0 and busy=0; start=1 loads vector=0, clears err_count, fail_vector and pass, and moves to APPLY.
REQ-014 APPLY: drive {a,b,c}=vector (a is the MSB); load the settle counter with SETTLE_CYCLES; move to SETTLE; busy=1 from this state through FINISH.
REQ-015 SETTLE: hold the stimulus; decrement the counter each cycle; move to CHECK in the cycle the counter reaches 1.
REQ-016 CHECK: compare y against expected = a|b|c for the current vector (0 only for vector 000).
REQ-017 On a mismatch in CHECK: increment err_count, saturating at 15; if this is the first mismatch of the run, capture vector into fail_vector.
REQ-018 Leaving CHECK: if vector==7, go to FINISH; otherwise increment vector and go to APPLY.
REQ-019 Each vector SHALL take exactly SETTLE_CYCLES+2 cycles; a full run SHALL take 8*(SETTLE_CYCLES+2) cycles from the start sample to FINISH entry.
REQ-020 FINISH: assert done for exactly one cycle; set pass=(err_count==0); drive a=b=c=0; return to IDLE.
REQ-021 start asserted while busy=1 SHALL be ignored and SHALL NOT restart or extend the run.
REQ-022 pass, err_count and fail_vector SHALL hold their values after FINISH until the next accepted start.
REQ-023 fail_vector SHALL read 000 when err_count==0.
REQ-024 y SHALL be treated as synchronous to clk; no synchronizer is required.

Reset
REQ-025 rst=1 SHALL immediately force IDLE with a=b=c=0, busy=0, done=0, pass=0, err_count=0, fail_vector=0, vector=0 and the settle counter at 0.
REQ-026 rst asserted mid-run SHALL abort the run with no done pulse; after rst is released, a new start is required.

Configuration
REQ-027 Macro OR3_TESTER_STOP_ON_FAIL_EN defined: the first mismatch in CHECK SHALL go directly to FINISH, so err_count is at most 1 and pass=0.
REQ-028 Macro OR3_TESTER_STOP_ON_FAIL_EN undefined: all 8 vectors SHALL always be applied, per REQ-018.

Verification
REQ-029 Correct model y=a|b|c, SETTLE_CYCLES=2, start pulse -> done pulses 32 cycles after start is sampled; pass=1, err_count=0, fail_vector=000; vectors 000..111 applied in order.
REQ-030 y stuck at 0 -> err_count=7, fail_vector=001, pass=0.
REQ-031 y stuck at 1 -> err_count=1, fail_vector=000, pass=0.
REQ-032 rst pulsed during vector 011 -> all outputs return to reset values immediately; no done pulse; a following start gives a full clean run (pass=1).
REQ-033 start re-pulsed at vectors 010 and 101 during a run -> ignored; done still arrives at cycle 32 with unchanged results.
REQ-034 With OR3_TESTER_STOP_ON_FAIL_EN defined and y stuck at 0 -> FINISH after vector 001 (8 cycles for SETTLE_CYCLES=2); err_count=1, fail_vector=001, pass=0.
